debounce_sync: RTL and testbench

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

---
 rtl/debounce_sync.sv | 94 +++++++++
 tb/tb_debounce_sync.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// Multi-channel input synchronizer + debouncer with optional edge pulses.
// clock/reset (async, active-low), in_raw -> level/rise/fall/changed; edges need DEBOUNCE_SYNC_EDGE_EN.
module debounce_sync #(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] take;
  logic [WIDTH-1:0] snew;

  for (genvar c = 0; c < WIDTH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   lvl_q;
    logic                   lvl_d;
    logic                   tk;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
      tk    = 1'b0;
      cnt_d = '0;
      lvl_d = lvl_q;
      if (s != lvl_q) begin
        if (cnt_q == CNT_MAX) begin
          tk    = 1'b1;
          lvl_d = s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        sync_q <= '0;
        cnt_q  <= '0;
        lvl_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], in_raw[c]};
        cnt_q  <= cnt_d;
        lvl_q  <= lvl_d;
      end
    end

    assign level[c] = lvl_q;
    assign take[c]  = tk;
    assign snew[c]  = s;
  end

`ifdef DEBOUNCE_SYNC_EDGE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic             chg_q;

  // Pulses are registered on the same edge that updates level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      rise_q <= take & snew;
      fall_q <= take & ~snew;
      chg_q  <= |take;
    end
  end

  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = chg_q;
`else
  logic unused_edge;
  assign unused_edge = ^{take, snew};
  assign rise    = '0;
  assign fall    = '0;
  assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed self-checking bench for debounce_sync (WIDTH=2, 2 stages, 4 cycles).
// Edge expectations follow DEBOUNCE_SYNC_EDGE_EN; level expectations are identical.
module tb_debounce_sync;

`ifdef DEBOUNCE_SYNC_EDGE_EN
  localparam logic [4:0] PM = 5'h1f;
`else
  localparam logic [4:0] PM = 5'h00;
`endif

  logic       clock;
  logic       reset;
  logic [1:0] in_raw;
  logic [1:0] level;
  logic [1:0] rise;
  logic [1:0] fall;
  logic       changed;

  int errors;
  int checks;

  logic [6:0] obs;
  logic [6:0] exp;

  debounce_sync #(
    .WIDTH(2),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_raw(in_raw),
    .level(level),
    .rise(rise),
    .fall(fall),
    .changed(changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign obs = {level, rise, fall, changed};

  task automatic step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    in_raw = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if (obs !== 7'b0) begin
        errors++;
        $display("FAIL reset_post: got %b want %b", obs, 7'b0);
      end
      step();
      checks++;
      if (obs !== 7'b0) begin
        errors++;
        $display("FAIL reset_neg: got %b want %b", obs, 7'b0);
      end
    end
    in_raw = 2'b00;
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b want %b", obs, 7'b0);
    end
  endtask

  task automatic test_rise();
    in_raw = 2'b01;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (obs !== 7'b0) begin
        errors++;
        $display("FAIL rise_wait%0d: got %b want %b", i, obs, 7'b0);
      end
    end
    step();
    exp = {2'b01, 5'b01_00_1 & PM};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL rise_edge6: got %b want %b", obs, exp);
    end
    step();
    exp = {2'b01, 5'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL rise_after: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_glitch();
    in_raw = 2'b11;
    for (int i = 0; i < 3; i++) step();
    in_raw = 2'b01;
    exp = {2'b01, 5'b0};
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL glitch%0d: got %b want %b", i, obs, exp);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    in_raw = 2'b10;
    exp = {2'b01, 5'b0};
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL b2b_wait%0d: got %b want %b", i, obs, exp);
      end
    end
    step();
    exp = {2'b10, 5'b10_01_1 & PM};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL b2b_edge6: got %b want %b", obs, exp);
    end
    step();
    exp = {2'b10, 5'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL b2b_after: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_reset_midcount();
    in_raw = 2'b11;
    for (int i = 0; i < 4; i++) step();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL mid_async: got %b want %b", obs, 7'b0);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs !== 7'b0) begin
        errors++;
        $display("FAIL mid_hold%0d: got %b want %b", i, obs, 7'b0);
      end
    end
    reset = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (obs !== 7'b0) begin
        errors++;
        $display("FAIL mid_requal%0d: got %b want %b", i, obs, 7'b0);
      end
    end
    step();
    exp = {2'b11, 5'b11_00_1 & PM};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL mid_edge6: got %b want %b", obs, exp);
    end
    step();
    exp = {2'b11, 5'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL mid_after: got %b want %b", obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    in_raw = 2'b00;
    step();
    test_reset();
    test_rise();
    test_glitch();
    test_back_to_back();
    test_reset_midcount();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
